// File: rtl/sl3p_lock_pkg.sv
// ---------------------------------------------------------------------------
// sl3p_lock_pkg
// Shared definitions for the 64b/66b word-lock logic.
//   lock_state_t : 2-bit per-lane hunt/lock state encoding
//   LOSS_SAT     : saturation value of the per-lane lock-loss counter
//   hdr_good()   : a sync header is good when its two bits differ
//   cnt_width()  : counter width for a given limit, never below one bit
// ---------------------------------------------------------------------------
package sl3p_lock_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_TEST   = 2'd1,
        ST_SLIP   = 2'd2,
        ST_LOCKED = 2'd3
    } lock_state_t;

    localparam logic [7:0] LOSS_SAT = 8'hFF;

    // 01 and 10 are legal sync headers; 00 and 11 never occur on an aligned lane.
    function automatic logic hdr_good(input logic [1:0] h);
        return h[1] ^ h[0];
    endfunction

    // A limit of 1 would give a zero-width counter, so clamp to one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/sl3p_lane_lock.sv
// ---------------------------------------------------------------------------
// sl3p_lane_lock
// Block-lock state machine for one 64b/66b lane. Hunts for the sync header
// boundary by requesting SERDES bit slips, declares lock after LOCK_GOOD
// consecutive good headers and drops lock after BAD_MAX bad headers inside
// one WIN_LEN-header monitor window.
// Ports:
//   clk, arst      : clock, asynchronous active-high reset
//   hdr_valid, hdr : sync header strobe and the two header bits
//   lane_ena       : lane enable; low holds the lane in a cleared FLUSH
//   bitslip        : one-cycle slip request to the SERDES
//   word_lock      : registered block-lock indication
//   hunt_wrap      : pulse when the slip index wraps back to zero
//   lock_loss_cnt  : saturating count of lock losses (held while disabled)
// ---------------------------------------------------------------------------
module sl3p_lane_lock
    import sl3p_lock_pkg::*;
#(
    parameter int LOCK_GOOD = 64,
    parameter int WIN_LEN   = 1024,
    parameter int BAD_MAX   = 16,
    parameter int SETTLE    = 32,
    parameter int SLIP_MAX  = 66
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       hdr_valid,
    input  logic [1:0] hdr,
    input  logic       lane_ena,
    output logic       bitslip,
    output logic       word_lock,
    output logic       hunt_wrap,
    output logic [7:0] lock_loss_cnt
);

    localparam int FW = cnt_width(SETTLE);
    localparam int GW = cnt_width(LOCK_GOOD);
    localparam int WW = cnt_width(WIN_LEN);
    localparam int BW = cnt_width(BAD_MAX);
    localparam int SW = cnt_width(SLIP_MAX);

    localparam logic [FW-1:0] FLUSH_LAST = FW'(SETTLE - 1);
    localparam logic [GW-1:0] GOOD_LAST  = GW'(LOCK_GOOD - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WIN_LEN - 1);
    localparam logic [BW-1:0] BAD_LAST   = BW'(BAD_MAX - 1);
    localparam logic [SW-1:0] SLIP_LAST  = SW'(SLIP_MAX - 1);

    lock_state_t   state, state_n;
    logic [FW-1:0] flush_cnt, flush_n;
    logic [GW-1:0] good_cnt, good_n;
    logic [WW-1:0] win_cnt, win_n;
    logic [BW-1:0] bad_cnt, bad_n;
    logic [SW-1:0] slip_idx, slip_n;
    logic [7:0]    loss_n;
    logic          is_good;
    logic          is_bad;

    assign is_good = hdr_valid & hdr_good(hdr);
    assign is_bad  = hdr_valid & ~hdr_good(hdr);

    // State, counters and the lock flag. word_lock is its own flop fed from
    // the next state so it rises on the same edge that enters LOCKED.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state         <= ST_FLUSH;
            flush_cnt     <= '0;
            good_cnt      <= '0;
            win_cnt       <= '0;
            bad_cnt       <= '0;
            slip_idx      <= '0;
            lock_loss_cnt <= '0;
            word_lock     <= 1'b0;
        end else begin
            state         <= state_n;
            flush_cnt     <= flush_n;
            good_cnt      <= good_n;
            win_cnt       <= win_n;
            bad_cnt       <= bad_n;
            slip_idx      <= slip_n;
            lock_loss_cnt <= loss_n;
            word_lock     <= (state_n == ST_LOCKED);
        end
    end

    // Next-state and counter update. A disabled lane is parked in FLUSH with
    // everything cleared except the lock-loss history.
    always_comb begin
        state_n = state;
        flush_n = flush_cnt;
        good_n  = good_cnt;
        win_n   = win_cnt;
        bad_n   = bad_cnt;
        slip_n  = slip_idx;
        loss_n  = lock_loss_cnt;
        if (!lane_ena) begin
            state_n = ST_FLUSH;
            flush_n = '0;
            good_n  = '0;
            win_n   = '0;
            bad_n   = '0;
            slip_n  = '0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state_n = ST_TEST;
                        flush_n = '0;
                        good_n  = '0;
                    end else begin
                        flush_n = flush_cnt + 1'b1;
                    end
                end
                ST_TEST: begin
                    if (is_bad) begin
                        state_n = ST_SLIP;
                    end else if (is_good) begin
                        if (good_cnt == GOOD_LAST) begin
                            state_n = ST_LOCKED;
                            win_n   = '0;
                            bad_n   = '0;
                        end else begin
                            good_n = good_cnt + 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    slip_n  = (slip_idx == SLIP_LAST) ? '0 : slip_idx + 1'b1;
                    state_n = ST_FLUSH;
                    flush_n = '0;
                end
                ST_LOCKED: begin
                    // Losing lock takes priority over a coincident window end.
                    if (is_bad && (bad_cnt == BAD_LAST)) begin
                        state_n = ST_FLUSH;
                        flush_n = '0;
                        win_n   = '0;
                        bad_n   = '0;
                        if (lock_loss_cnt != LOSS_SAT) begin
                            loss_n = lock_loss_cnt + 1'b1;
                        end
                    end else if (hdr_valid) begin
                        if (win_cnt == WIN_LAST) begin
                            win_n = '0;
                            bad_n = '0;
                        end else begin
                            win_n = win_cnt + 1'b1;
                            if (is_bad) begin
                                bad_n = bad_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_n = ST_FLUSH;
                    flush_n = '0;
                end
            endcase
        end
    end

    // Slip request and wrap pulse decode straight from the SLIP state; the
    // enable gate keeps a lane that is being switched off from slipping.
    assign bitslip   = lane_ena && (state == ST_SLIP);
    assign hunt_wrap = lane_ena && (state == ST_SLIP) && (slip_idx == SLIP_LAST);

endmodule

// File: rtl/sl3p_word_lock_nln.sv
// ---------------------------------------------------------------------------
// sl3p_word_lock_nln
// Multi-lane 64b/66b word (block) lock. One sl3p_lane_lock per lane plus a
// registered all-lanes-locked summary.
// Ports:
//   clk, arst      : clock, asynchronous active-high reset (release must be
//                    synchronised by the instantiating logic)
//   hdr_valid      : per-lane header strobe           [LANES]
//   hdr            : lane i header at [2i+1:2i]       [2*LANES]
//   lane_ena       : per-lane enable                  [LANES]
//   bitslip        : per-lane slip request            [LANES]
//   word_lock      : per-lane block lock              [LANES]
//   all_lock       : every enabled lane locked (and at least one enabled)
//   hunt_wrap      : per-lane slip-index wrap pulse   [LANES]
//   lock_loss_cnt  : lane i saturating count at [8i+7:8i]
// ---------------------------------------------------------------------------
module sl3p_word_lock_nln
    import sl3p_lock_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int LOCK_GOOD = 64,
    parameter int WIN_LEN   = 1024,
    parameter int BAD_MAX   = 16,
    parameter int SETTLE    = 32,
    parameter int SLIP_MAX  = 66
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [LANES-1:0]     hdr_valid,
    input  logic [2*LANES-1:0]   hdr,
    input  logic [LANES-1:0]     lane_ena,
    output logic [LANES-1:0]     bitslip,
    output logic [LANES-1:0]     word_lock,
    output logic                 all_lock,
    output logic [LANES-1:0]     hunt_wrap,
    output logic [8*LANES-1:0]   lock_loss_cnt
);

    logic all_ok;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sl3p_lane_lock #(
            .LOCK_GOOD (LOCK_GOOD),
            .WIN_LEN   (WIN_LEN),
            .BAD_MAX   (BAD_MAX),
            .SETTLE    (SETTLE),
            .SLIP_MAX  (SLIP_MAX)
        ) u_lane (
            .clk           (clk),
            .arst          (arst),
            .hdr_valid     (hdr_valid[i]),
            .hdr           (hdr[2*i+1:2*i]),
            .lane_ena      (lane_ena[i]),
            .bitslip       (bitslip[i]),
            .word_lock     (word_lock[i]),
            .hunt_wrap     (hunt_wrap[i]),
            .lock_loss_cnt (lock_loss_cnt[8*i+7:8*i])
        );
    end

    // Disabled lanes are treated as locked; with no lane enabled the link is
    // not considered locked at all.
    assign all_ok = (|lane_ena) && (&(word_lock | ~lane_ena));

    // Summary flag is registered, so it trails the last lane lock by a cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            all_lock <= 1'b0;
        end else begin
            all_lock <= all_ok;
        end
    end

endmodule

// File: tb/tb_sl3p_word_lock_nln.sv
// ---------------------------------------------------------------------------
// tb_sl3p_word_lock_nln
// Directed bench for sl3p_word_lock_nln with default parameters and 4 lanes.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Header nibbles: 8'h55 = all lanes 01, 8'h75 = lane 2 at 11,
// 8'h65 = lane 2 at 10, 8'h54 = lane 0 at 00, 8'h5D = lane 1 at 11.
// ---------------------------------------------------------------------------
module tb_sl3p_word_lock_nln;

    localparam int LANES = 4;

    logic                 clk = 1'b0;
    logic                 arst;
    logic [LANES-1:0]     hdr_valid;
    logic [2*LANES-1:0]   hdr;
    logic [LANES-1:0]     lane_ena;
    logic [LANES-1:0]     bitslip;
    logic [LANES-1:0]     word_lock;
    logic                 all_lock;
    logic [LANES-1:0]     hunt_wrap;
    logic [8*LANES-1:0]   lock_loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sl3p_word_lock_nln #(
        .LANES     (LANES),
        .LOCK_GOOD (64),
        .WIN_LEN   (1024),
        .BAD_MAX   (16),
        .SETTLE    (32),
        .SLIP_MAX  (66)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .hdr_valid     (hdr_valid),
        .hdr           (hdr),
        .lane_ena      (lane_ena),
        .bitslip       (bitslip),
        .word_lock     (word_lock),
        .all_lock      (all_lock),
        .hunt_wrap     (hunt_wrap),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] h, input logic [3:0] v, input logic [3:0] ena);
        hdr       = h;
        hdr_valid = v;
        lane_ena  = ena;
    endtask

    // Hold reset over a few edges, then release on a falling edge so the next
    // rising edge is edge 1 of the run.
    task automatic resetDut(input logic [7:0] h, input logic [3:0] ena);
        arst = 1'b1;
        applyStimulus(h, 4'hF, ena);
        repeat (3) @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitLock(input int lane);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (word_lock[lane]) break;
        end
        checkOutput("wait_lock", 32'(word_lock[lane]), 32'd1);
    endtask

    // n consecutive bad headers on lane 1, then back to good headers.
    task automatic badBurst(input int n);
        applyStimulus(8'h5D, 4'hF, 4'hF);
        repeat (n) @(negedge clk);
        applyStimulus(8'h55, 4'hF, 4'hF);
    endtask

    initial begin
        logic [3:0] slip_seen;
        int pulses, last, slips, wraps, stray;

        arst = 1'b1;
        applyStimulus(8'h00, 4'h0, 4'h0);
        runCycles(2);
        checkOutput("rst_word_lock", 32'(word_lock), 32'd0);
        checkOutput("rst_all_lock", 32'(all_lock), 32'd0);
        checkOutput("rst_bitslip", 32'(bitslip), 32'd0);
        checkOutput("rst_hunt_wrap", 32'(hunt_wrap), 32'd0);
        checkOutput("rst_loss_cnt", lock_loss_cnt, 32'd0);

        // All lanes clean: lock after 32 flush cycles plus 64 good headers.
        resetDut(8'h55, 4'hF);
        slip_seen = '0;
        for (int n = 1; n <= 97; n++) begin
            @(negedge clk);
            slip_seen |= bitslip;
            if (n == 95) checkOutput("a1_lock_early", 32'(word_lock), 32'd0);
            if (n == 96) begin
                checkOutput("a1_lock_rise", 32'(word_lock), 32'hF);
                checkOutput("a1_all_early", 32'(all_lock), 32'd0);
            end
            if (n == 97) checkOutput("a1_all_lock", 32'(all_lock), 32'd1);
        end
        checkOutput("a1_no_slip", 32'(slip_seen), 32'd0);

        // Lane 2 bad for the first 200 headers: slips every 34 cycles, then
        // locks 64 good headers after the TEST entry at edge 202.
        resetDut(8'h75, 4'hF);
        pulses = 0;
        last = 0;
        slip_seen = '0;
        for (int n = 1; n <= 270; n++) begin
            @(negedge clk);
            if (n + 1 > 200) hdr = 8'h65;
            slip_seen |= bitslip & 4'b1011;
            if (bitslip[2]) begin
                pulses++;
                if (pulses == 1) checkOutput("a2_first_slip", 32'(n), 32'd33);
                else checkOutput("a2_slip_period", 32'(n - last), 32'd34);
                last = n;
            end
            if (n == 265) checkOutput("a2_lock2_early", 32'(word_lock[2]), 32'd0);
            if (n == 266) checkOutput("a2_lock2_rise", 32'(word_lock[2]), 32'd1);
        end
        checkOutput("a2_slip_count", 32'(pulses), 32'd5);
        checkOutput("a2_other_slip", 32'(slip_seen), 32'd0);

        // Lane 0 stuck at 00: wrap pulse on slips 66 and 132 only.
        resetDut(8'h54, 4'hF);
        slips = 0;
        wraps = 0;
        stray = 0;
        last = 0;
        for (int n = 1; n <= 5000 && slips < 133; n++) begin
            @(negedge clk);
            if (hunt_wrap[0] && !bitslip[0]) stray++;
            if (bitslip[0]) begin
                slips++;
                if (hunt_wrap[0]) wraps++;
                if (slips == 65 || slips == 66 || slips == 67 || slips == 131 || slips == 132)
                    checkOutput($sformatf("b_wrap_slip%0d", slips), 32'(hunt_wrap[0]),
                                32'((slips % 66) == 0));
                if (slips == 67) checkOutput("b_period_after_wrap", 32'(n - last), 32'd34);
                last = n;
            end
        end
        checkOutput("b_slip_total", 32'(slips), 32'd133);
        checkOutput("b_wrap_total", 32'(wraps), 32'd2);
        checkOutput("b_wrap_stray", 32'(stray), 32'd0);

        // Lane 1 loss-of-lock thresholds, window clearing and saturation.
        resetDut(8'h55, 4'hF);
        waitLock(1);
        applyStimulus(8'h5D, 4'b1101, 4'hF);
        runCycles(16);
        applyStimulus(8'h55, 4'hF, 4'hF);
        runCycles(1);
        checkOutput("c_invalid_ignored", 32'(word_lock[1]), 32'd1);
        badBurst(15);
        runCycles(2);
        checkOutput("c_15bad_kept", 32'(word_lock[1]), 32'd1);
        checkOutput("c_15bad_cnt", 32'(lock_loss_cnt[15:8]), 32'd0);
        runCycles(1100);
        badBurst(15);
        runCycles(2);
        checkOutput("c_new_window_kept", 32'(word_lock[1]), 32'd1);
        runCycles(1100);
        badBurst(16);
        runCycles(1);
        checkOutput("c_16bad_drop", 32'(word_lock[1]), 32'd0);
        checkOutput("c_loss_one", 32'(lock_loss_cnt[15:8]), 32'd1);
        for (int k = 2; k <= 300; k++) begin
            waitLock(1);
            badBurst(16);
            runCycles(1);
            if (k == 254) checkOutput("c_loss_254", 32'(lock_loss_cnt[15:8]), 32'd254);
            if (k == 255) checkOutput("c_loss_255", 32'(lock_loss_cnt[15:8]), 32'd255);
        end
        checkOutput("c_loss_saturated", 32'(lock_loss_cnt[15:8]), 32'd255);
        checkOutput("c_loss_other_lanes", 32'({lock_loss_cnt[31:16], lock_loss_cnt[7:0]}), 32'd0);

        // Disable a locked lane: lock drops, history held, relock from scratch.
        waitLock(1);
        applyStimulus(8'h55, 4'hF, 4'b1101);
        runCycles(1);
        checkOutput("c_dis_unlock", 32'(word_lock[1]), 32'd0);
        runCycles(2);
        checkOutput("c_dis_all_lock", 32'(all_lock), 32'd1);
        checkOutput("c_dis_bitslip", 32'(bitslip[1]), 32'd0);
        checkOutput("c_dis_loss_held", 32'(lock_loss_cnt[15:8]), 32'd255);
        applyStimulus(8'h55, 4'hF, 4'hF);
        for (int n = 1; n <= 96; n++) begin
            @(negedge clk);
            if (n == 95) checkOutput("c_reen_early", 32'(word_lock[1]), 32'd0);
            if (n == 96) checkOutput("c_reen_lock", 32'(word_lock[1]), 32'd1);
        end

        // Masked lanes, empty mask and asynchronous reset while locked.
        resetDut(8'h75, 4'b1011);
        runCycles(120);
        checkOutput("d_mask_all_lock", 32'(all_lock), 32'd1);
        checkOutput("d_mask_word_lock", 32'(word_lock), 32'hB);
        applyStimulus(8'h75, 4'hF, 4'h0);
        runCycles(2);
        checkOutput("d_none_all_lock", 32'(all_lock), 32'd0);
        checkOutput("d_none_word_lock", 32'(word_lock), 32'd0);
        checkOutput("d_none_bitslip", 32'(bitslip), 32'd0);
        applyStimulus(8'h55, 4'hF, 4'hF);
        runCycles(100);
        checkOutput("d_relock_all", 32'(all_lock), 32'd1);
        @(posedge clk);
        #2 arst = 1'b1;
        #1;
        checkOutput("d_arst_word_lock", 32'(word_lock), 32'd0);
        checkOutput("d_arst_all_lock", 32'(all_lock), 32'd0);
        checkOutput("d_arst_bitslip", 32'(bitslip), 32'd0);
        checkOutput("d_arst_hunt_wrap", 32'(hunt_wrap), 32'd0);
        checkOutput("d_arst_loss_cnt", lock_loss_cnt, 32'd0);
        runCycles(2);
        arst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
